// File: rtl/arb_mux.sv
// N-channel arbiter feeding a one-deep registered output stage.
// Supports round-robin or fixed-priority selection and keeps a saturating count of accepted words.
module arb_mux #(
    parameter int N  = 8,
    parameter int W  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    output logic [W-1:0]    out_data,
    output logic [SW-1:0]   out_sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [15:0]     xfer_cnt
);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;
    logic          r_out_valid;
    logic [SW-1:0] r_ptr;
    logic [15:0]   r_xfer_cnt;

    logic [W-1:0]  w_chan_data [N];
    logic [N-1:0]  w_rr_mask;
    logic [N-1:0]  w_rr_hi;
    logic [SW-1:0] w_rr_winner;
    logic [SW-1:0] w_fp_winner;
    logic [SW-1:0] w_winner;
    logic [N-1:0]  w_winner_onehot;
    logic [SW-1:0] w_ptr_next;
    logic [15:0]   w_cnt_next;
    logic          w_any_valid;
    logic          w_load_en;
    logic          w_drain;

    // Index of the lowest set bit; zero when nothing is set.
    function automatic logic [SW-1:0] lowest_set(input logic [N-1:0] v);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = SW'(i);
            end
        end
        return idx;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_chan
            assign w_chan_data[gi]     = in_data[gi*W +: W];
            assign w_rr_mask[gi]       = (SW'(gi) >= r_ptr);
            assign w_winner_onehot[gi] = (w_winner == SW'(gi));
        end
    endgenerate

    // Round-robin: prefer requesters at or above ptr, otherwise wrap to the lowest one.
    assign w_rr_hi     = in_valid & w_rr_mask;
    assign w_rr_winner = (|w_rr_hi) ? lowest_set(w_rr_hi) : lowest_set(in_valid);
    assign w_fp_winner = lowest_set(in_valid);
    assign w_winner    = mode ? w_fp_winner : w_rr_winner;

    assign w_any_valid = |in_valid;
    assign w_load_en   = (!r_out_valid || out_ready) && w_any_valid;
    assign w_drain     = r_out_valid && out_ready && !w_any_valid;

    assign w_ptr_next  = (w_winner == SW'(N - 1)) ? '0 : w_winner + SW'(1);
    assign w_cnt_next  = (&r_xfer_cnt) ? r_xfer_cnt : r_xfer_cnt + 16'd1;

    // rst gates the handshake directly so no word is granted while reset is held.
    assign in_ready  = (w_load_en && !rst) ? w_winner_onehot : '0;

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
    assign xfer_cnt  = r_xfer_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= '0;
            r_xfer_cnt  <= '0;
        end else begin
            if (w_load_en) begin
                r_out_data  <= w_chan_data[w_winner];
                r_out_sel   <= w_winner;
                r_out_valid <= 1'b1;
                r_xfer_cnt  <= w_cnt_next;
                if (!mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux (N=8, W=4, channel i carries 8+i).
// A vector table covers arbitration, stalls and draining; reset and saturation are hand sequences.
module tb_arb_mux;

    localparam int N  = 8;
    localparam int W  = 4;
    localparam int SW = 3;

    logic            clk;
    logic            rst;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_sel;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     xfer_cnt;

    int errors = 0;
    int checks = 0;

    arb_mux #(.N(N), .W(W), .SW(SW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  iv;
        logic        md;
        logic        ordy;
        logic [7:0]  ir;
        logic        ov;
        logic [2:0]  sel;
        logic [3:0]  data;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive at the falling edge, check the grant before the rising edge, check outputs just after it.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        in_valid  = v.iv;
        mode      = v.md;
        out_ready = v.ordy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(v.ir));
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(v.ov));
        chk("out_sel",   32'(out_sel),   32'(v.sel));
        chk("out_data",  32'(out_data),  32'(v.data));
        chk("xfer_cnt",  32'(xfer_cnt),  32'(v.cnt));
        $display("vec %0d: iv=%h mode=%0d ordy=%0d -> ir=%h ov=%0d sel=%0d data=%h cnt=%0d",
                 idx, v.iv, v.md, v.ordy, in_ready, out_valid, out_sel, out_data, xfer_cnt);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            in_data[i*W +: W] = 4'(8 + i);
        end
        rst       = 1'b0;
        in_valid  = '0;
        mode      = 1'b0;
        out_ready = 1'b1;

        //        iv     md    rdy   ir     ov    sel   data   cnt
        // round-robin sweep with everyone requesting
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'd1});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h02, 1'b1, 3'd1, 4'h9, 16'd2});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h04, 1'b1, 3'd2, 4'hA, 16'd3});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 4'hB, 16'd4});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h10, 1'b1, 3'd4, 4'hC, 16'd5});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h20, 1'b1, 3'd5, 4'hD, 16'd6});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h40, 1'b1, 3'd6, 4'hE, 16'd7});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 3'd7, 4'hF, 16'd8});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'd9});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h02, 1'b1, 3'd1, 4'h9, 16'd10});
        // fixed priority: channel 0 always wins, ptr (2) held
        tbl.push_back('{8'hFF, 1'b1, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'd11});
        tbl.push_back('{8'hFF, 1'b1, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'd12});
        tbl.push_back('{8'hFF, 1'b1, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'd13});
        // ptr 2 -> 1 via channel 0, then 7/0/7 wrap with channels 0 and 7
        tbl.push_back('{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'd14});
        tbl.push_back('{8'h81, 1'b0, 1'b1, 8'h80, 1'b1, 3'd7, 4'hF, 16'd15});
        tbl.push_back('{8'h81, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'd16});
        tbl.push_back('{8'h81, 1'b0, 1'b1, 8'h80, 1'b1, 3'd7, 4'hF, 16'd17});
        // downstream stall for three cycles, then release
        tbl.push_back('{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 4'hF, 16'd17});
        tbl.push_back('{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 4'hF, 16'd17});
        tbl.push_back('{8'hFF, 1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 4'hF, 16'd17});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'd18});
        // drain to empty, idle, load into empty stage with out_ready low, then stall
        tbl.push_back('{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3'd0, 4'h8, 16'd18});
        tbl.push_back('{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 4'h8, 16'd18});
        tbl.push_back('{8'h04, 1'b0, 1'b0, 8'h04, 1'b1, 3'd2, 4'hA, 16'd19});
        tbl.push_back('{8'h04, 1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 4'hA, 16'd19});
        // mode switch applies immediately; ptr stays 3 across the fixed cycle
        tbl.push_back('{8'hFF, 1'b1, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'd20});
        tbl.push_back('{8'hFF, 1'b0, 1'b1, 8'h08, 1'b1, 3'd3, 4'hB, 16'd21});

        // power-on reset
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // asynchronous reset between edges while a word is held
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_xfer_cnt",  32'(xfer_cnt),  32'd0);
        chk("arst_out_sel",   32'(out_sel),   32'd0);
        chk("arst_out_data",  32'(out_data),  32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_valid", 32'(out_valid), 32'd0);
        chk("arst_hold_cnt",   32'(xfer_cnt),  32'd0);
        $display("async reset: ov=%0d cnt=%0d ir=%h", out_valid, xfer_cnt, in_ready);
        @(negedge clk);
        in_valid = 8'h00;
        rst      = 1'b0;
        // ptr was 4 before reset; channel 0 winning proves it restarted at 0
        apply('{8'hFF, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'd1}, 100);
        apply('{8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 3'd4, 4'hC, 16'd2}, 101);

        // counter saturation
        @(negedge clk);
        in_valid = 8'h00;
        force dut.r_xfer_cnt = 16'hFFFE;
        #1;
        release dut.r_xfer_cnt;
        #1;
        chk("sat_preload", 32'(xfer_cnt), 32'hFFFE);
        apply('{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'hFFFF}, 200);
        apply('{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'hFFFF}, 201);
        apply('{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 4'h8, 16'hFFFF}, 202);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
